// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master round-robin arbiter sharing one pipelined Wishbone B4 slave
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   mN_cyc/stb/we/adr/dat/sel_i   master N request (N = 0 instruction cache, 1 data cache)
//   mN_stall/ack/err_o, mN_dat_o  master N response; read data is broadcast to both
//   s_cyc/stb/we/adr/dat/sel_o    request towards the shared slave
//   s_stall/ack/err_i, s_dat_i    response from the shared slave
module wb_arbiter2 #(
    parameter int WB_AW   = 12,
    parameter int WB_DW   = 32,
    parameter int WB_SL   = WB_DW / 8,
    parameter int MAX_OUT = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [WB_AW-1:0] m0_adr_i,
    input  logic [WB_DW-1:0] m0_dat_i,
    input  logic [WB_SL-1:0] m0_sel_i,
    output logic             m0_stall_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    output logic [WB_DW-1:0] m0_dat_o,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [WB_AW-1:0] m1_adr_i,
    input  logic [WB_DW-1:0] m1_dat_i,
    input  logic [WB_SL-1:0] m1_sel_i,
    output logic             m1_stall_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic [WB_DW-1:0] m1_dat_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [WB_AW-1:0] s_adr_o,
    output logic [WB_DW-1:0] s_dat_o,
    output logic [WB_SL-1:0] s_sel_o,
    input  logic             s_stall_i,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    input  logic [WB_DW-1:0] s_dat_i
);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [OW-1:0] MAX_W = OW'(MAX_OUT);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_last;
    logic [OW-1:0] r_outst;
    logic          w_room;
    logic          w_busy;
    logic          w_accept;
    logic          w_resp;

    assign w_room   = r_outst < MAX_W;
    assign w_busy   = r_outst != '0;
    assign w_accept = s_stb_o & ~s_stall_i;
    // responses with nothing outstanding (or while idle) are spurious and dropped
    assign w_resp   = (r_state != IDLE) & (s_ack_i | s_err_i) & w_busy;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_comb begin
        w_next     = r_state;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_adr_o    = '0;
        s_dat_o    = '0;
        s_sel_o    = '0;
        m0_stall_o = 1'b1;
        m1_stall_o = 1'b1;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m1_err_o   = 1'b0;
        case (r_state)
            IDLE: begin
                // on a tie the master that did not hold the bus last wins
                if (m0_cyc_i && (!m1_cyc_i || r_last))
                    w_next = GNT0;
                else if (m1_cyc_i)
                    w_next = GNT1;
            end
            GNT0: begin
                s_cyc_o    = m0_cyc_i;
                s_stb_o    = m0_stb_i & w_room;
                s_we_o     = m0_we_i;
                s_adr_o    = m0_adr_i;
                s_dat_o    = m0_dat_i;
                s_sel_o    = m0_sel_i;
                m0_stall_o = s_stall_i | ~w_room;
                m0_ack_o   = s_ack_i & w_busy;
                m0_err_o   = s_err_i & w_busy;
                if (!m0_cyc_i)
                    w_next = IDLE;
            end
            GNT1: begin
                s_cyc_o    = m1_cyc_i;
                s_stb_o    = m1_stb_i & w_room;
                s_we_o     = m1_we_i;
                s_adr_o    = m1_adr_i;
                s_dat_o    = m1_dat_i;
                s_sel_o    = m1_sel_i;
                m1_stall_o = s_stall_i | ~w_room;
                m1_ack_o   = s_ack_i & w_busy;
                m1_err_o   = s_err_i & w_busy;
                if (!m1_cyc_i)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_outst <= '0;
        end else begin
            r_state <= w_next;
            // release aborts the cycle: anything still in flight is forgotten
            if (r_state != IDLE && w_next == IDLE) begin
                r_last  <= (r_state == GNT1);
                r_outst <= '0;
            end else if (w_accept && !w_resp)
                r_outst <= r_outst + OW'(1);
            else if (!w_accept && w_resp)
                r_outst <= r_outst - OW'(1);
        end
    end
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed self-checking bench for wb_arbiter2 with a delayed-ack slave model
module tb_wb_arbiter2;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [11:0] m0_adr, m1_adr;
    logic [31:0] m0_dat, m1_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_stall_o, m0_ack_o, m0_err_o, m1_stall_o, m1_ack_o, m1_err_o;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [11:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_stall_i, s_ack_i, s_err_i;
    logic [31:0] s_dat_i;
    logic        inj_ack, inj_err;
    int          dly;
    int          n_total = 0;
    int          n_pass = 0;

    typedef struct packed {
        logic       v;
        logic       we;
        logic [3:0] a;
    } ent_t;

    ent_t        sh[4] = '{default: '0};
    logic [31:0] mem[16];

    always #5 clk = ~clk;

    wb_arbiter2 #(.WB_AW(12), .WB_DW(32), .MAX_OUT(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_stall_o(m0_stall_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_stall_o(m1_stall_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_stall_i(s_stall_i), .s_ack_i(s_ack_i),
        .s_err_i(s_err_i), .s_dat_i(s_dat_i)
    );

    // slave: acks each accepted strobe dly cycles later, never stalls
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            sh[i] <= sh[i+1];
        sh[3] <= '0;
        if (s_stb_o && !s_stall_i) begin
            sh[dly-1] <= '{v: 1'b1, we: s_we_o, a: s_adr_o[5:2]};
            if (s_we_o)
                mem[s_adr_o[5:2]] <= s_dat_o;
        end
    end

    assign s_ack_i = (sh[0].v & ~inj_err) | inj_ack;
    assign s_err_i = inj_err;
    assign s_dat_i = mem[sh[0].a];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
        {m0_adr, m1_adr, m0_dat, m1_dat, m0_sel, m1_sel} = '0;
        {inj_ack, inj_err} = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int issued, acks, stalls, acks_at3, maxo;

    initial begin
        s_stall_i = 1'b0;
        dly = 1;
        rst_n = 1'b0;
        clear_inputs();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 12'h123; m0_we = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s_cyc", s_cyc_o, 0);
        chk("rst_s_stb", s_stb_o, 0);
        chk("rst_m0_stall", m0_stall_o, 1);
        chk("rst_m1_stall", m1_stall_o, 1);
        chk("rst_m0_ack", m0_ack_o, 0);
        chk("rst_s_adr", s_adr_o, 0);
        chk("rst_s_we", s_we_o, 0);

        // tie and round robin
        do_reset();
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        #1 chk("tie_pre_cyc", s_cyc_o, 0);
        @(negedge clk); #1;
        chk("tie_s_cyc", s_cyc_o, 1);
        chk("tie_m0_stall", m0_stall_o, 0);
        chk("tie_m1_stall", m1_stall_o, 1);
        m0_cyc = 1'b0;
        @(negedge clk); #1;
        chk("gap_s_cyc", s_cyc_o, 0);
        chk("gap_m1_stall", m1_stall_o, 1);
        @(negedge clk); #1;
        chk("gnt1_s_cyc", s_cyc_o, 1);
        chk("gnt1_m1_stall", m1_stall_o, 0);
        chk("gnt1_m0_stall", m0_stall_o, 1);
        m1_cyc = 1'b0;
        @(negedge clk); #1;
        chk("rel1_s_cyc", s_cyc_o, 0);
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        @(negedge clk); #1;
        chk("rr_m0_stall", m0_stall_o, 0);
        chk("rr_m1_stall", m1_stall_o, 1);

        // single master write then read
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 12'h010;
        m0_dat = 32'hDEADBEEF; m0_sel = 4'hF;
        #1 chk("sm_pre_cyc", s_cyc_o, 0);
        @(negedge clk); #1;
        chk("sm_s_cyc", s_cyc_o, 1);
        chk("sm_s_stb", s_stb_o, 1);
        chk("sm_s_we", s_we_o, 1);
        chk("sm_s_adr", s_adr_o, 32'h010);
        chk("sm_s_dat", s_dat_o, 32'hDEADBEEF);
        chk("sm_s_sel", s_sel_o, 32'hF);
        chk("sm_ack_early", m0_ack_o, 0);
        chk("sm_m1_stall", m1_stall_o, 1);
        @(negedge clk); #1;
        chk("sm_wr_ack", m0_ack_o, 1);
        m0_we = 1'b0;
        @(negedge clk); #1;
        chk("sm_rd_ack", m0_ack_o, 1);
        chk("sm_rd_dat", m0_dat_o, 32'hDEADBEEF);
        chk("sm_m1_ack", m1_ack_o, 0);
        chk("sm_m1_stall2", m1_stall_o, 1);
        m0_stb = 1'b0;
        @(negedge clk); #1;
        chk("sm_ack_end", m0_ack_o, 0);
        chk("sm_outst", dut.r_outst, 0);

        // outstanding limit with three-cycle ack
        do_reset();
        dly = 3;
        issued = 0; acks = 0; stalls = 0; acks_at3 = -1; maxo = 0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 12'h010; m0_sel = 4'hF;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (m0_ack_o) acks++;
            if (int'(dut.r_outst) > maxo) maxo = int'(dut.r_outst);
            if (s_cyc_o && m0_stb && m0_stall_o) stalls++;
            if (m0_stb && !m0_stall_o) begin
                issued++;
                if (issued == 3) acks_at3 = acks;
            end
            @(negedge clk);
            if (issued == 4) m0_stb = 1'b0;
        end
        chk("lim_issued", issued, 4);
        chk("lim_acks", acks, 4);
        chk("lim_stall_cycles", stalls, 2);
        chk("lim_acks_before_third", acks_at3, 2);
        chk("lim_max_outst", maxo, 2);
        #1 chk("lim_outst_end", dut.r_outst, 0);
        m0_cyc = 1'b0;

        // abort with one strobe in flight
        do_reset();
        dly = 3;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 12'h010;
        @(negedge clk); #1;
        chk("ab_s_cyc", s_cyc_o, 1);
        chk("ab_s_stb", s_stb_o, 1);
        @(negedge clk); #1;
        chk("ab_outst1", dut.r_outst, 1);
        m1_stb = 1'b0; m1_cyc = 1'b0;
        @(negedge clk); #1;
        chk("ab_idle_cyc", s_cyc_o, 0);
        chk("ab_outst0", dut.r_outst, 0);
        @(negedge clk); #1;
        chk("ab_late_ack_present", s_ack_i, 1);
        chk("ab_m0_ack", m0_ack_o, 0);
        chk("ab_m1_ack", m1_ack_o, 0);

        // error path, spurious ack, async reset mid-burst
        do_reset();
        dly = 1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 12'h010;
        @(negedge clk);
        @(negedge clk);
        m0_stb = 1'b0; inj_err = 1'b1;
        #1;
        chk("err_m0_err", m0_err_o, 1);
        chk("err_m0_ack", m0_ack_o, 0);
        chk("err_m1_err", m1_err_o, 0);
        @(negedge clk);
        inj_err = 1'b0;
        #1;
        chk("err_clear", m0_err_o, 0);
        chk("err_outst", dut.r_outst, 0);
        inj_ack = 1'b1;
        #1 chk("spur_m0_ack", m0_ack_o, 0);
        @(negedge clk); #1;
        chk("spur_outst", dut.r_outst, 0);
        inj_ack = 1'b0; m0_stb = 1'b1;
        @(negedge clk); #1;
        chk("burst_s_cyc", s_cyc_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_s_cyc", s_cyc_o, 0);
        chk("arst_s_stb", s_stb_o, 0);
        chk("arst_m0_stall", m0_stall_o, 1);
        chk("arst_m1_stall", m1_stall_o, 1);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master round-robin arbiter that shares one pipelined Wishbone B4 slave port, typically the single `wb_mem` instance, between the instruction cache (master 0) and the data cache (master 1) in the pipelined-plus-cache core.
- Grants the bus for a whole `cyc` and multiplexes request signals to the slave.
- Tracks outstanding pipelined strobes so that returning ack/err/data reach only the owning master.
- Throttles issue at a configurable outstanding depth.

## Interface
Parameters:
- `WB_AW`, 12: address width.
- `WB_DW`, 32: data width; `WB_SL = WB_DW/8` select lanes.
- `MAX_OUT`, 4: maximum accepted-but-unacknowledged strobes, 1..15.

Ports:
- `clk_i`  in  1  sole clock; all state on rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `mN_cyc_i`, `mN_stb_i`, `mN_we_i`  in  1 each  master N request (N = 0, 1).
- `mN_adr_i`  in  `WB_AW`  master N address.
- `mN_dat_i`  in  `WB_DW`  master N write data.
- `mN_sel_i`  in  `WB_SL`  master N byte selects.
- `mN_stall_o`, `mN_ack_o`, `mN_err_o`  out  1 each  master N response.
- `mN_dat_o`  out  `WB_DW`  master N read data.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  slave request.
- `s_adr_o`  out  `WB_AW`  slave address.
- `s_dat_o`  out  `WB_DW`  slave write data.
- `s_sel_o`  out  `WB_SL`  slave byte selects.
- `s_stall_i`, `s_ack_i`, `s_err_i`  in  1 each  slave response.
- `s_dat_i`  in  `WB_DW`  slave read data.

## Operation
- Registered state:
  - FSM state: IDLE, GNT0, GNT1.
  - `last`: 1-bit id of the previously granted master.
  - `outst`: counter of width `$clog2(MAX_OUT+1)`.
- IDLE:
  - `s_cyc_o = s_stb_o = 0`; both `mN_stall_o = 1`.
  - If exactly one `mN_cyc_i` is high, go to GNTN.
  - If both are high, grant the master ≠ `last`.
- GNTN:
  - `s_cyc_o = mN_cyc_i`.
  - `s_we/adr/dat/sel_o` = master N's signals.
  - `s_stb_o = mN_stb_i & (outst < MAX_OUT)`.
  - `mN_stall_o = s_stall_i | (outst == MAX_OUT)`.
  - The other master sees `stall = 1`, `ack = 0`, `err = 0`.
- Accepted strobe: `s_stb_o & !s_stall_i`. Then `outst += 1`.
- Response: `s_ack_i | s_err_i` with `outst > 0`.
  - Forwarded as `mN_ack_o` / `mN_err_o` to the granted master only.
  - `outst -= 1`.
  - Accept and response in the same cycle leave `outst` unchanged.
- Spurious response (`outst == 0`, or state IDLE): dropped and not forwarded. `outst` stays 0 and never underflows.
- `m0_dat_o = m1_dat_o = s_dat_i` (broadcast). Data is valid only with that master's ack.
- Release: in GNTN with `mN_cyc_i = 0`:
  - Next state IDLE; `last <= N`; `outst <= 0`.
  - This is a Wishbone abort: responses still in flight are dropped.
- The grant is never preempted while `mN_cyc_i` stays high.

## Timing
- Reset (asynchronous assert, synchronous-to-`clk_i` release):
  - State IDLE; `last = 1`, so master 0 wins the first tie; `outst = 0`.
  - All outputs take their IDLE values: `s_cyc_o = 0`, `s_stb_o = 0`, `mN_ack_o = 0`, `mN_err_o = 0`, `mN_stall_o = 1`.
  - `s_adr/dat/sel/we_o` = 0.
- Reset mid-transaction: all of the above apply immediately, without waiting for a clock. In-flight acks after release are dropped.
- Grant latency: `mN_cyc_i` high at edge k in IDLE gives GNTN and `s_cyc_o = 1` after edge k. The first strobe can be accepted in that cycle.
- With `wb_mem` (ack one cycle after strobe, no stall), the first ack reaches the master two cycles after its `cyc` is seen in IDLE.
- Request muxing and response gating are combinational from the registered state. There is no added latency on ack/err/data.
- Switch-over: every release costs exactly one IDLE cycle before the next grant.
- Throughput: one strobe per cycle while `outst < MAX_OUT` and `s_stall_i = 0`.

## Test plan
- Single master: after reset, m0 holds `cyc`/`stb` for a write of 0xDEADBEEF to 0x010 with sel 0xF, then a read of 0x010.
  - Required: `s_cyc_o` rises after one cycle.
  - `m0_ack_o` pulses once per strobe; the read returns 0xDEADBEEF.
  - m1 sees stall=1, ack=0.
- Tie and round-robin: both `cyc` rise in the same cycle.
  - Required: m0 is granted first.
  - After m0 drops `cyc`: exactly one IDLE cycle, then GNT1.
  - With m0 and m1 both requesting again after m1 drops: m0 is granted.
- Outstanding limit, `MAX_OUT = 2`, slave ack delayed three cycles:
  - m0 issues 4 back-to-back strobes. The third is stalled until the first ack.
  - Ack count = 4; `outst` returns to 0.
- Abort: m1 drops `cyc` with `outst = 1`.
  - Required: IDLE next cycle, `outst = 0`.
  - The late `s_ack_i` is forwarded to neither master.
- Error path and async reset:
  - `s_err_i` on m0's read gives `m0_err_o = 1` and `m0_ack_o = 0` for one cycle.
  - Asserting `rst_ni = 0` mid-burst, between clock edges, immediately forces `s_cyc_o = 0` and both stalls to 1.
